// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access sequencer: issues one req/ready transaction per load or store,
// stalls the front of the pipeline while it is outstanding and abandons it after TIMEOUT cycles.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  BEOutM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FlushW,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            acc;
  logic            unused_addr_bits;

  assign acc = MemReadM | MemWriteM;
  // Address is word aligned; the byte offset is carried by the byte enables instead.
  assign unused_addr_bits = ^ALUOutM[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      ReadDataM <= '0;
      BusErr    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (acc) begin
            mem_addr  <= {ALUOutM[31:2], 2'b00};
            mem_wdata <= WriteDataM;
            mem_we    <= MemWriteM;
            mem_be    <= MemWriteM ? BEOutM : 4'b1111;
            mem_req   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) ReadDataM <= mem_rdata;
            state_q <= StDone;
          end else if (cnt_q == CntLast) begin
            mem_req <= 1'b0;
            BusErr  <= 1'b1;
            if (!mem_we) ReadDataM <= '0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // The instruction still sitting in MEM here was just serviced; do not re-sample acc.
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    StallM = rst & (((state_q == StIdle) & acc) | (state_q == StBusy));
    FlushW = StallM;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage access controller for the five-stage pipelined MIPS core. It sequences MEM-stage loads and stores onto a data memory with a variable-latency req/ready handshake. While an access is outstanding it freezes the F/D/E/M pipeline registers and inserts bubbles into the MEM/WB register. When the access completes it delivers the read word to the MEM/WB register. It sits between the EX/MEM register outputs and the MEM/WB register inputs.

## Interface

- TIMEOUT, 255: the maximum number of BUSY cycles spent waiting for mem_ready before the access is abandoned. The value must be at least 1.

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- ALUOutM  in  32  effective address
- WriteDataM  in  32  store data
- BEOutM  in  4  store byte enables
- ReadDataM  out  32  captured load word, fed to MEM/WB register
- StallM  out  1  freezes F/D/E/M registers
- FlushW  out  1  clears MEM/WB register (bubble)
- BusErr  out  1  sticky timeout flag
- mem_req  out  1  memory request
- mem_we  out  1  1 means write
- mem_addr  out  32  word address {ALUOutM[31:2],2'b00}
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accepts/completes the request
- mem_rdata  in  32  read data, valid when mem_ready is high

## Operation

- Access condition: acc = MemReadM | MemWriteM. If both inputs are high, the access is treated as a write.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If acc is high, latch the request registers at the clock edge:
    - mem_addr ← {ALUOutM[31:2],2'b00}
    - mem_wdata ← WriteDataM
    - mem_we ← MemWriteM
    - mem_be ← BEOutM for a write, 4'b1111 for a read
    - mem_req ← 1
    - clear the timeout counter
  - Then go to BUSY. Otherwise remain in IDLE.
- BUSY: mem_req and all request fields are held stable.
  - If mem_ready=1: drop mem_req, then go to DONE. For a read, also set ReadDataM ← mem_rdata.
  - Else, if the counter equals TIMEOUT-1: drop mem_req, set BusErr ← 1, ReadDataM ← 32'h0, then go to DONE.
  - Else increment the counter.
- DONE: go to IDLE unconditionally. acc is not sampled in DONE, so the instruction still in MEM this cycle is not re-issued.
- ReadDataM changes only on read completion or read timeout. Writes leave it unchanged.
- BusErr is sticky and is cleared only by reset.
- Counter width is $clog2(TIMEOUT+1).

## Timing

- StallM is combinational: StallM = (state==IDLE & acc) | (state==BUSY). It is forced to 0 while rst is low.
- FlushW = StallM, so the MEM/WB register captures a bubble on every stalled edge.
- Zero-wait memory (mem_ready=1 in the first BUSY cycle):
  - Cycle 0: IDLE, stall.
  - Cycle 1: BUSY, mem_req=1, stall.
  - Cycle 2: DONE, StallM=0, and MEM/WB captures ReadDataM.
  - Result: 2 stall cycles and 3 cycles in MEM.
- With k wait cycles (mem_ready first high in BUSY cycle k+1), there are 2+k stall cycles.
- Timeout: BUSY lasts exactly TIMEOUT cycles, then DONE follows.
- Back-to-back accesses: the second access is detected in the IDLE cycle that follows DONE. There is no overlap between accesses.
- mem_req is asserted only from registers and never glitches combinationally.
- Reset: asynchronous assertion (rst=0) immediately forces the following, even mid-access with no completion handshake:
  - state IDLE, mem_req 0, mem_we 0
  - mem_addr 0, mem_wdata 0, mem_be 0
  - ReadDataM 0, BusErr 0, counter 0
  - StallM 0, FlushW 0
- Memory must tolerate a request being withdrawn by reset.

## Test plan

- Read, zero-wait: MemReadM=1, ALUOutM=32'h0000_1006, mem_ready=1, mem_rdata=32'hCAFE_F00D.
  - mem_addr=32'h0000_1004, mem_be=4'b1111.
  - StallM/FlushW high for 2 cycles.
  - ReadDataM=32'hCAFE_F00D in DONE.
- Store with 3 wait cycles: MemWriteM=1, WriteDataM=32'h1234_5678, BEOutM=4'b0011, mem_ready high in the 4th BUSY cycle.
  - mem_req held for 4 cycles with mem_we=1, mem_be=4'b0011.
  - StallM high for 5 cycles.
  - ReadDataM unchanged.
- Timeout with TIMEOUT=4 and mem_ready stuck at 0.
  - mem_req high for exactly 4 cycles.
  - BusErr=1 from DONE onward, ReadDataM=0.
  - A later successful read leaves BusErr=1.
- Back-to-back: a load followed directly by a load, both zero-wait.
  - Each access stalls for 2 cycles.
  - The first access's mem_req is not re-asserted during DONE.
  - Exactly 2 requests are seen.
- Reset mid-BUSY: rst=0 asynchronously during a read in BUSY.
  - All outputs go to 0 before the next clk edge.
  - After release, the access is re-issued from IDLE if MemReadM is still high.
- Idle pipeline: MemReadM=MemWriteM=0 for 10 cycles.
  - StallM, FlushW and mem_req stay 0.
